axi_dac_jesd204_tx_seq: RTL and testbench
=========================================

// Module: axi_dac_jesd204_tx_seq
// PURPOSE
//  Start/stop sequencer for the JESD204 DAC transmit datapath, in the dac_clk (tx_clk) domain between DMA and link framing.
//  Gates sample requests (dac_valid) and data until the link has been ready for a programmed time and, optionally, an external sync arrives.
//  While running it zero-fills DMA underflow, and on link loss or software stop it returns to a safe all-zero output.
//  It also counts underflow events for the register map.
// PARAMETERS
//  NUM_LANES     4   lanes; data width is NUM_LANES*32
//  NUM_CHANNELS  2   converter channels; width of dac_ch_enable/dac_valid
//  READY_WAIT   16   consecutive tx_ready-high cycles required before leaving WAIT_READY (>=1)
//  CNT_WIDTH    16   width of underflow counter (>=2)
// PORTS
//  dac_clk          in   1                 datapath clock (tx_clk, line-rate/40)
//  dac_rst          in   1                 asynchronous, active-high reset
//  dac_start        in   1                 level; 1 = run requested (already synchronised to dac_clk)
//  dac_ext_sync_en  in   1                 level; 1 = wait for dac_ext_sync before RUN
//  dac_ext_sync     in   1                 single-cycle sync pulse, synchronous to dac_clk
//  tx_ready         in   1                 link layer ready for data
//  dac_ch_enable    in   NUM_CHANNELS      per-channel enable from register map
//  dac_valid        out  NUM_CHANNELS      per-channel sample request to DMA
//  dac_ddata        in   NUM_LANES*32      DMA sample data, valid the cycle dac_valid is high
//  dac_dunf         in   1                 DMA underflow flag, qualifies dac_ddata in the same cycle
//  dac_data         out  NUM_LANES*32      data to JESD framing
//  dac_unf_clr      in   1                 single-cycle clear of dac_unf_count
//  dac_unf_count    out  CNT_WIDTH         saturating underflow cycle count
//  dac_state        out  2                 0=IDLE 1=WAIT_READY 2=ARMED 3=RUN
//  dac_running      out  1                 1 when dac_state==RUN
// BEHAVIOUR
//  Reset: state IDLE; dac_valid=0, dac_data=0, dac_unf_count=0, ready counter=0; all outputs zero immediately and asynchronously.
//  FSM transitions are registered; dac_start=0 forces IDLE from any state (highest priority).
//   IDLE: dac_start=1 -> WAIT_READY, and the ready counter is cleared.
//   WAIT_READY: counter increments on each cycle with tx_ready=1.
//    tx_ready=0 -> counter cleared, no exit.
//    tx_ready=1 with counter==READY_WAIT-1 -> ARMED if dac_ext_sync_en, otherwise RUN.
//    State therefore leaves WAIT_READY exactly READY_WAIT cycles after entry when tx_ready is held high.
//   ARMED: dac_ext_sync=1 -> RUN; tx_ready=0 -> WAIT_READY (counter cleared); tx_ready=0 wins over a simultaneous sync.
//   RUN: tx_ready=0 -> WAIT_READY (counter cleared), and the underflow counter holds.
//  dac_valid = (state==RUN) ? dac_ch_enable : 0. It is decoded from the state register, so it is glitch-free.
//  dac_data is registered, with latency 1: dac_data <= (state==RUN && !dac_dunf) ? dac_ddata : 0.
//   Zeros therefore appear on the cycle after the state leaves RUN.
//  dac_dunf is ignored outside RUN.
//  dac_unf_count: +1 on each RUN cycle with dac_dunf=1.
//   Saturates at all-ones with no wrap.
//   dac_unf_clr sets it to 0 and wins over a simultaneous increment.
//   The count is retained across IDLE/WAIT_READY; only reset or clr zeroes it.
//  dac_ext_sync outside ARMED is ignored; it is not latched.
//  dac_ch_enable changes take effect the same cycle on dac_valid.
// TESTING
//  1 READY_WAIT=16, ext_en=0, tx_ready=1, dac_start rises -> WAIT_READY at T; RUN at T+16; dac_valid=2'b11; dac_data=dac_ddata at T+17.
//  2 As 1, but tx_ready=0 for one cycle at T+10 -> counter restarts; RUN at T+27.
//  3 ext_en=1 -> ARMED at T+16, dac_valid=0. Sync pulse at T+40 -> RUN at T+41. Sync pulsed in WAIT_READY -> ignored, stays ARMED.
//  4 RUN, dac_ddata=0xA5A5..., dunf=1 for 3 cycles -> dac_data=0 for 3 cycles (1 cycle later), count=3; clr+dunf same cycle -> count=0.
//  5 CNT_WIDTH=4, 20 underflow cycles -> count sticks at 15; tx_ready drop mid-RUN -> WAIT_READY, dac_valid=0 same cycle, dac_data=0 next.
//  6 dac_rst asserted mid-RUN between clock edges -> dac_valid, dac_data and count go 0 immediately; after release state=IDLE until dac_start.

Source files
------------

// File: rtl/axi_dac_jesd204_tx_seq.sv
// Start/stop sequencer for the JESD204 DAC transmit path: gates DMA requests and data
// until the link has been stably ready (and optionally synced), zero-fills underflow.
module axi_dac_jesd204_tx_seq #(
    parameter int NUM_LANES    = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int READY_WAIT   = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                      dac_clk,
    input  logic                      dac_rst,
    input  logic                      dac_start,
    input  logic                      dac_ext_sync_en,
    input  logic                      dac_ext_sync,
    input  logic                      tx_ready,
    input  logic [NUM_CHANNELS-1:0]   dac_ch_enable,
    output logic [NUM_CHANNELS-1:0]   dac_valid,
    input  logic [NUM_LANES*32-1:0]   dac_ddata,
    input  logic                      dac_dunf,
    output logic [NUM_LANES*32-1:0]   dac_data,
    input  logic                      dac_unf_clr,
    output logic [CNT_WIDTH-1:0]      dac_unf_count,
    output logic [1:0]                dac_state,
    output logic                      dac_running
);

    localparam int RW = (READY_WAIT > 1) ? $clog2(READY_WAIT) : 1;
    localparam logic [RW-1:0] RDY_LAST = RW'(READY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        ARMED      = 2'd2,
        RUN        = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [RW-1:0]          rdy_cnt_reg, rdy_cnt_next;
    logic [CNT_WIDTH-1:0]   unf_cnt_reg;
    logic                   run;

    assign run = (state_reg == RUN);

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            state_reg   <= IDLE;
            rdy_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rdy_cnt_reg <= rdy_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rdy_cnt_next = rdy_cnt_reg;
        if (!dac_start) begin
            state_next   = IDLE;
            rdy_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next   = WAIT_READY;
                    rdy_cnt_next = '0;
                end
                WAIT_READY: begin
                    if (!tx_ready) begin
                        rdy_cnt_next = '0;
                    end else if (rdy_cnt_reg == RDY_LAST) begin
                        rdy_cnt_next = '0;
                        state_next   = dac_ext_sync_en ? ARMED : RUN;
                    end else begin
                        rdy_cnt_next = rdy_cnt_reg + 1'b1;
                    end
                end
                ARMED: begin
                    // Link loss takes priority over a coincident sync pulse
                    if (!tx_ready) begin
                        state_next   = WAIT_READY;
                        rdy_cnt_next = '0;
                    end else if (dac_ext_sync) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    if (!tx_ready) begin
                        state_next   = WAIT_READY;
                        rdy_cnt_next = '0;
                    end
                end
            endcase
        end
    end

    // Underflow counter: clear wins, saturates, holds on the RUN cycle where the link drops
    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            unf_cnt_reg <= '0;
        end else if (dac_unf_clr) begin
            unf_cnt_reg <= '0;
        end else if (run && tx_ready && dac_dunf && !(&unf_cnt_reg)) begin
            unf_cnt_reg <= unf_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge dac_clk or posedge dac_rst) begin
                if (dac_rst) begin
                    dac_data[gi*32 +: 32] <= '0;
                end else begin
                    dac_data[gi*32 +: 32] <= (run && !dac_dunf) ? dac_ddata[gi*32 +: 32] : 32'd0;
                end
            end
        end
    endgenerate

    assign dac_valid     = run ? dac_ch_enable : '0;
    assign dac_unf_count = unf_cnt_reg;
    assign dac_state     = state_reg;
    assign dac_running   = run;

endmodule

// File: tb/tb_axi_dac_jesd204_tx_seq.sv
// Bench for axi_dac_jesd204_tx_seq: directed sequencing scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_axi_dac_jesd204_tx_seq;

    localparam int NL = 4;
    localparam int NC = 2;
    localparam int RWAIT = 16;
    localparam int CW = 4;
    localparam int DW = NL * 32;
    localparam int CMAX = (1 << CW) - 1;

    logic          dac_clk = 1'b0;
    logic          dac_rst = 1'b0;
    logic          dac_start = 1'b0;
    logic          dac_ext_sync_en = 1'b0;
    logic          dac_ext_sync = 1'b0;
    logic          tx_ready = 1'b0;
    logic [NC-1:0] dac_ch_enable = '0;
    logic [NC-1:0] dac_valid;
    logic [DW-1:0] dac_ddata = '0;
    logic          dac_dunf = 1'b0;
    logic [DW-1:0] dac_data;
    logic          dac_unf_clr = 1'b0;
    logic [CW-1:0] dac_unf_count;
    logic [1:0]    dac_state;
    logic          dac_running;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: mode 0 idle, 1 waiting for ready, 2 armed, 3 running
    int            m_mode;
    int            m_streak;
    int            m_unf;
    logic [DW-1:0] m_data;

    axi_dac_jesd204_tx_seq #(
        .NUM_LANES(NL), .NUM_CHANNELS(NC), .READY_WAIT(RWAIT), .CNT_WIDTH(CW)
    ) dut (
        .dac_clk(dac_clk), .dac_rst(dac_rst), .dac_start(dac_start),
        .dac_ext_sync_en(dac_ext_sync_en), .dac_ext_sync(dac_ext_sync),
        .tx_ready(tx_ready), .dac_ch_enable(dac_ch_enable), .dac_valid(dac_valid),
        .dac_ddata(dac_ddata), .dac_dunf(dac_dunf), .dac_data(dac_data),
        .dac_unf_clr(dac_unf_clr), .dac_unf_count(dac_unf_count),
        .dac_state(dac_state), .dac_running(dac_running)
    );

    always #5 dac_clk = ~dac_clk;

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_streak = 0; m_unf = 0; m_data = '0;
    endtask

    // Advance the model with the inputs present before the edge, then clock the DUT
    task automatic step();
        int nmode;
        int nstreak;
        m_data = (m_mode == 3 && !dac_dunf) ? dac_ddata : '0;
        if (dac_unf_clr) m_unf = 0;
        else if (m_mode == 3 && tx_ready && dac_dunf && m_unf < CMAX) m_unf = m_unf + 1;
        nmode = m_mode;
        nstreak = m_streak;
        if (!dac_start) begin
            nmode = 0; nstreak = 0;
        end else if (m_mode == 0) begin
            nmode = 1; nstreak = 0;
        end else if (m_mode == 1) begin
            if (!tx_ready) nstreak = 0;
            else if (m_streak + 1 == RWAIT) begin nmode = dac_ext_sync_en ? 2 : 3; nstreak = 0; end
            else nstreak = m_streak + 1;
        end else if (!tx_ready) begin
            nmode = 1; nstreak = 0;
        end else if (m_mode == 2 && dac_ext_sync) begin
            nmode = 3;
        end
        m_mode = nmode;
        m_streak = nstreak;
        @(posedge dac_clk);
        #1;
    endtask

    function automatic logic [NC-1:0] exp_valid();
        return (m_mode == 3) ? dac_ch_enable : '0;
    endfunction

    task automatic go_idle();
        dac_start = 1'b0; dac_ext_sync = 1'b0; dac_dunf = 1'b0; dac_unf_clr = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        dac_rst = 1'b1;
        #2;
        model_reset();
        @(posedge dac_clk); #1;
        dac_rst = 1'b0;
        vectors++;
        if (dac_state !== 2'd0 || dac_valid !== '0 || dac_data !== '0 || dac_unf_count !== '0 || dac_running !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: state=%0d valid=%b data=%h count=%0d run=%b, required all zero",
                     dac_state, dac_valid, dac_data, dac_unf_count, dac_running);
        end
    endtask

    task automatic test_startup();
        dac_ext_sync_en = 1'b0; tx_ready = 1'b1; dac_ch_enable = 2'b11;
        dac_start = 1'b1;
        step();
        vectors++;
        if (dac_state !== 2'd1) begin
            miscompares++; $display("FAIL startup_enter: state=%0d required 1", dac_state);
        end
        for (int i = 1; i < RWAIT; i++) step();
        vectors++;
        if (dac_state !== 2'd1 || dac_valid !== 2'b00) begin
            miscompares++; $display("FAIL startup_t15: state=%0d valid=%b required 1/00", dac_state, dac_valid);
        end
        step();
        vectors++;
        if (dac_state !== 2'd3 || dac_valid !== 2'b11 || dac_running !== 1'b1) begin
            miscompares++; $display("FAIL startup_run: state=%0d valid=%b run=%b required 3/11/1", dac_state, dac_valid, dac_running);
        end
        dac_ddata = rand_data();
        step();
        vectors++;
        if (dac_data !== dac_ddata) begin
            miscompares++; $display("FAIL startup_data: data=%h required %h", dac_data, dac_ddata);
        end
    endtask

    task automatic test_ready_glitch();
        go_idle();
        dac_start = 1'b1; tx_ready = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        tx_ready = 1'b0;
        step();
        tx_ready = 1'b1;
        for (int i = 0; i < RWAIT - 1; i++) step();
        vectors++;
        if (dac_state !== 2'd1) begin
            miscompares++; $display("FAIL glitch_t26: state=%0d required 1", dac_state);
        end
        step();
        vectors++;
        if (dac_state !== 2'd3) begin
            miscompares++; $display("FAIL glitch_t27: state=%0d required 3", dac_state);
        end
    endtask

    task automatic test_ext_sync();
        go_idle();
        dac_ext_sync_en = 1'b1; dac_start = 1'b1; tx_ready = 1'b1;
        step();
        for (int i = 0; i < RWAIT; i++) begin
            dac_ext_sync = (i == 5);
            step();
        end
        dac_ext_sync = 1'b0;
        vectors++;
        if (dac_state !== 2'd2 || dac_valid !== 2'b00) begin
            miscompares++; $display("FAIL armed_t16: state=%0d valid=%b required 2/00", dac_state, dac_valid);
        end
        for (int i = RWAIT; i < 40; i++) step();
        vectors++;
        if (dac_state !== 2'd2) begin
            miscompares++; $display("FAIL armed_t40: state=%0d required 2", dac_state);
        end
        dac_ext_sync = 1'b1;
        step();
        dac_ext_sync = 1'b0;
        vectors++;
        if (dac_state !== 2'd3 || dac_valid !== 2'b11) begin
            miscompares++; $display("FAIL sync_run: state=%0d valid=%b required 3/11", dac_state, dac_valid);
        end
        dac_ext_sync_en = 1'b0;
    endtask

    task automatic test_underflow();
        logic [DW-1:0] pat;
        pat = {NL{32'hA5A5A5A5}};
        dac_unf_clr = 1'b1;
        step();
        dac_unf_clr = 1'b0;
        dac_ddata = pat;
        dac_dunf = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dac_data !== '0) begin
                miscompares++; $display("FAIL unf_zero[%0d]: data=%h required 0", i, dac_data);
            end
        end
        dac_dunf = 1'b0;
        step();
        vectors++;
        if (dac_data !== pat || dac_unf_count !== 4'd3) begin
            miscompares++; $display("FAIL unf_count: data=%h count=%0d required %h/3", dac_data, dac_unf_count, pat);
        end
        dac_dunf = 1'b1; dac_unf_clr = 1'b1;
        step();
        dac_dunf = 1'b0; dac_unf_clr = 1'b0;
        vectors++;
        if (dac_unf_count !== 4'd0) begin
            miscompares++; $display("FAIL unf_clr_wins: count=%0d required 0", dac_unf_count);
        end
    endtask

    task automatic test_saturate_and_drop();
        logic [DW-1:0] last;
        dac_dunf = 1'b1;
        for (int i = 0; i < 20; i++) step();
        dac_dunf = 1'b0;
        vectors++;
        if (dac_unf_count !== 4'd15) begin
            miscompares++; $display("FAIL unf_saturate: count=%0d required 15", dac_unf_count);
        end
        last = rand_data();
        dac_ddata = last;
        tx_ready = 1'b0;
        step();
        vectors++;
        if (dac_state !== 2'd1 || dac_valid !== 2'b00 || dac_data !== last) begin
            miscompares++; $display("FAIL drop_state: state=%0d valid=%b data=%h required 1/00/%h", dac_state, dac_valid, dac_data, last);
        end
        step();
        vectors++;
        if (dac_data !== '0 || dac_unf_count !== 4'd15) begin
            miscompares++; $display("FAIL drop_zero: data=%h count=%0d required 0/15", dac_data, dac_unf_count);
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        go_idle();
        dac_start = 1'b1; tx_ready = 1'b1; dac_ch_enable = 2'b01;
        for (int i = 0; i < RWAIT + 1; i++) step();
        dac_dunf = 1'b1;
        step();
        dac_dunf = 1'b0;
        dac_ddata = rand_data();
        step();
        #2;
        dac_rst = 1'b1;
        #1;
        vectors++;
        if (dac_valid !== '0 || dac_data !== '0 || dac_unf_count !== '0 || dac_state !== 2'd0) begin
            miscompares++; $display("FAIL async_reset: valid=%b data=%h count=%0d state=%0d required all zero",
                                    dac_valid, dac_data, dac_unf_count, dac_state);
        end
        dac_start = 1'b0;
        model_reset();
        @(posedge dac_clk); #3;
        dac_rst = 1'b0;
        @(posedge dac_clk); #1;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (dac_state !== 2'd0) begin
            miscompares++; $display("FAIL post_reset_idle: state=%0d required 0", dac_state);
        end
        dac_start = 1'b1;
        step();
        vectors++;
        if (dac_state !== 2'd1) begin
            miscompares++; $display("FAIL post_reset_start: state=%0d required 1", dac_state);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            dac_start       = ($urandom_range(0, 99) < 97);
            tx_ready        = ($urandom_range(0, 99) < 92);
            dac_ext_sync    = ($urandom_range(0, 99) < 10);
            dac_dunf        = ($urandom_range(0, 99) < 25);
            dac_unf_clr     = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 3) dac_ext_sync_en = ~dac_ext_sync_en;
            dac_ddata       = rand_data();
            dac_ch_enable   = NC'($urandom);
            #1;
            vectors++;
            if (dac_valid !== exp_valid()) begin
                miscompares++; $display("FAIL rand_valid_comb[%0d]: valid=%b required %b", n, dac_valid, exp_valid());
            end
            step();
            vectors++;
            if (dac_state !== 2'(m_mode) || dac_valid !== exp_valid() || dac_data !== m_data ||
                dac_unf_count !== CW'(m_unf) || dac_running !== (m_mode == 3)) begin
                miscompares++;
                $display("FAIL rand_cycle[%0d]: state=%0d valid=%b count=%0d data=%h required %0d/%b/%0d/%h",
                         n, dac_state, dac_valid, dac_unf_count, dac_data, m_mode, exp_valid(), m_unf, m_data);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_ready_glitch();
        test_ext_sync();
        test_underflow();
        test_saturate_and_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
